// File: rtl/vscale_core_scheduler.sv
// Round-robin owner select for the shared dmem arbiter. Ownership moves only at
// AHB-safe points, with a bounded quantum per grant and a switch counter.
module vscale_core_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int CORE_IDX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int QUANTUM        = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      core_req,
  input  logic [NUM_CORES-1:0]      core_lock,
  input  logic                      dmem_hready,
  output logic [CORE_IDX_WIDTH-1:0] next_core,
  output logic [CORE_IDX_WIDTH-1:0] active_core,
  output logic                      switch_pulse,
  output logic [31:0]               switch_count
);

  // state  | meaning
  // RUN    | next_core == active_core; owner may be handed over at a safe point
  // SWITCH | one cycle for the arbiter's cur_core to catch up; next_core held
  typedef enum logic {RUN = 1'b0, SWITCH = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] QMAX = CNT_WIDTH'(QUANTUM - 1);

  state_t                    state, state_nxt;
  logic [CNT_WIDTH-1:0]      qcnt, qcnt_nxt;
  logic [CORE_IDX_WIDTH-1:0] next_core_nxt;
  logic                      switch_pulse_nxt;
  logic [31:0]               switch_count_nxt;

  logic                      own_req, own_lock, safe, expired, found;
  logic [NUM_CORES-1:0]      others;
  logic [CORE_IDX_WIDTH-1:0] target;
  int                        act;

  // Owner request/lock and competing requesters, judged against the arbiter's view.
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    others   = core_req;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (active_core == CORE_IDX_WIDTH'(i)) begin
        own_req   = core_req[i];
        own_lock  = core_lock[i];
        others[i] = 1'b0;
      end
    end
    safe    = dmem_hready & ~own_lock;
    expired = (qcnt == QMAX);
  end

  // Rotating priority: nearest requester after the current owner, wrapping at NUM_CORES.
  always_comb begin
    act    = int'(active_core);
    found  = 1'b0;
    target = active_core;
    for (int k = 1; k < NUM_CORES; k++) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (!found && others[j] && (j == (act + k) % NUM_CORES)) begin
          found  = 1'b1;
          target = CORE_IDX_WIDTH'(j);
        end
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    next_core_nxt    = next_core;
    qcnt_nxt         = qcnt;
    switch_pulse_nxt = 1'b0;
    switch_count_nxt = switch_count;
    case (state)
      RUN: begin
        if (safe && found && (!own_req || expired)) begin
          next_core_nxt    = target;
          qcnt_nxt         = '0;
          switch_pulse_nxt = 1'b1;
          switch_count_nxt = switch_count + 32'd1;
          state_nxt        = SWITCH;
        end else if (core_req == '0) begin
          qcnt_nxt = '0;
        end else if (own_req && (qcnt < QMAX)) begin
          qcnt_nxt = qcnt + CNT_WIDTH'(1);
        end
      end
      SWITCH: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      next_core    <= '0;
      active_core  <= '0;
      switch_pulse <= 1'b0;
      switch_count <= '0;
      qcnt         <= '0;
    end else begin
      state        <= state_nxt;
      next_core    <= next_core_nxt;
      active_core  <= next_core;
      switch_pulse <= switch_pulse_nxt;
      switch_count <= switch_count_nxt;
      qcnt         <= qcnt_nxt;
    end
  end

endmodule
